vx_ipdom_ctrl: RTL

VX_IPDOM_CTRL -- requirements
Module: VX_ipdom_ctrl

---
 rtl/vx_ipdom_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/vx_ipdom_ctrl.sv
// IPDOM divergence controller: turns SPLIT/JOIN requests into reconvergence stack pushes/pops.
// Latency: request accepted at T, stack op in EXEC at T+1, response valid from T+2.
// Backpressure: one request in flight; req_ready only in IDLE, response held until rsp_ready.
module vx_ipdom_ctrl #(
    parameter int NUM_THREADS = 4,
    parameter int PC_WIDTH    = 32,
    localparam int STKW       = NUM_THREADS + PC_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_op,
    input  logic [NUM_THREADS-1:0] req_tmask,
    input  logic [NUM_THREADS-1:0] req_pred,
    input  logic [PC_WIDTH-1:0]    req_else_pc,

    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [NUM_THREADS-1:0] rsp_tmask,
    output logic [PC_WIDTH-1:0]    rsp_pc,
    output logic                   rsp_jump,
    output logic                   rsp_diverged,

    output logic                   stk_push,
    output logic                   stk_pop,
    output logic                   stk_pair,
    output logic [STKW-1:0]        stk_q1,
    output logic [STKW-1:0]        stk_q2,
    input  logic [STKW-1:0]        stk_d,
    input  logic                   stk_index,
    input  logic                   stk_empty,
    input  logic                   stk_full,

    output logic                   err_overflow,
    output logic                   err_underflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RSP  = 2'd2
    } state_t;

    localparam logic OP_SPLIT = 1'b0;

    state_t state, state_n;

    logic                   op_r;
    logic [NUM_THREADS-1:0] tmask_r;
    logic [NUM_THREADS-1:0] pred_r;
    logic [PC_WIDTH-1:0]    else_pc_r;

    logic [NUM_THREADS-1:0] taken;
    logic [NUM_THREADS-1:0] not_taken;
    logic                   diverged;
    logic                   accept;
    logic                   in_exec;

    // Requests are refused while reset is held so nothing starts under reset.
    assign req_ready = (state == S_IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == S_RSP);
    assign in_exec   = (state == S_EXEC) && !reset;

    assign taken     = tmask_r & pred_r;
    assign not_taken = tmask_r & ~pred_r;
    assign diverged  = (taken != '0) && (not_taken != '0);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state: EXEC is always a single cycle; RSP waits for the consumer.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (accept) state_n = S_EXEC;
            S_EXEC:  state_n = S_RSP;
            S_RSP:   if (rsp_ready) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Stack commands are issued only in EXEC; payloads stay zero unless pushing.
    always_comb begin
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        stk_pair = 1'b0;
        stk_q1   = '0;
        stk_q2   = '0;
        if (in_exec) begin
            if (op_r == OP_SPLIT) begin
                if (!stk_full) begin
                    stk_push = 1'b1;
                    // Reconvergence entry restores the full mask and never redirects.
                    stk_q1   = {tmask_r, {PC_WIDTH{1'b0}}};
                    if (diverged) begin
                        stk_pair = 1'b1;
                        stk_q2   = {not_taken, else_pc_r};
                    end
                end
            end else if (!stk_empty) begin
                stk_pop = 1'b1;
            end
        end
    end

    // Request capture on handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r      <= 1'b0;
            tmask_r   <= '0;
            pred_r    <= '0;
            else_pc_r <= '0;
        end else if (accept) begin
            op_r      <= req_op;
            tmask_r   <= req_tmask;
            pred_r    <= req_pred;
            else_pc_r <= req_else_pc;
        end
    end

    // Response and sticky error registers, computed once in EXEC and held through RSP.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_tmask     <= '0;
            rsp_pc        <= '0;
            rsp_jump      <= 1'b0;
            rsp_diverged  <= 1'b0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else if (state == S_EXEC) begin
            rsp_tmask    <= tmask_r;
            rsp_pc       <= '0;
            rsp_jump     <= 1'b0;
            rsp_diverged <= 1'b0;
            if (op_r == OP_SPLIT) begin
                if (stk_full) begin
                    err_overflow <= 1'b1;
                end else if (diverged) begin
                    rsp_tmask    <= taken;
                    rsp_diverged <= 1'b1;
                end
            end else begin
                if (stk_empty) begin
                    err_underflow <= 1'b1;
                end else begin
                    // Index 0 marks an else-path entry, which needs a PC redirect.
                    rsp_tmask <= stk_d[STKW-1:PC_WIDTH];
                    rsp_jump  <= ~stk_index;
                    if (!stk_index) begin
                        rsp_pc <= stk_d[PC_WIDTH-1:0];
                    end
                end
            end
        end
    end

endmodule
